// File: rtl/ows_pkg.sv
// Shared constants, FSM encoding and the reflected CRC-8 step for the 1-Wire ROM path.
package ows_pkg;

    localparam int UID_WIDTH = 64;
    localparam int CRC_WIDTH = 8;
    localparam int CNT_WIDTH = 7;
    localparam logic [CRC_WIDTH-1:0] CRC_POLY = 8'h8C;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } ows_state_e;

    // One bit of the Dallas CRC-8, LSB-first (reflected x^8+x^5+x^4+1).
    function automatic logic [CRC_WIDTH-1:0] crc8_step(input logic [CRC_WIDTH-1:0] crc,
                                                      input logic              din);
        logic fb;
        fb = crc[0] ^ din;
        return (crc >> 1) ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/ows_crc8_serial.sv
// Bit-serial reflected CRC-8, one bit per enable; clr wins over en.
module ows_crc8_serial
    import ows_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 din,
    output logic [CRC_WIDTH-1:0] crc
);

    // CRC register: clear on request, otherwise fold in one bit per enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc8_step(crc, din);
        end
    end

endmodule

// File: rtl/ows_rom_deshifter.sv
// Serial-to-parallel receiver for the 64-bit 1-Wire ROM frame with on-the-fly CRC-8.
module ows_rom_deshifter
    import ows_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 abort,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    output logic [UID_WIDTH-1:0] UID_Data,
    output logic                 data_valid,
    output logic                 crc_ok,
    output logic                 busy
);

    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(UID_WIDTH - 1);

    ows_state_e             state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [UID_WIDTH-1:0]   shreg;
    logic [UID_WIDTH-1:0]   shreg_nxt;
    logic [CRC_WIDTH-1:0]   crc;
    logic                   crc_clr;
    logic                   crc_en;
    logic                   accept_bit;

    // A bit is taken only in SHIFT and only when nothing of higher priority is pending.
    assign accept_bit = (state == ST_SHIFT) && bit_valid && !abort && !frame_start;
    assign crc_clr    = frame_start && !abort;
    assign crc_en     = accept_bit;
    assign shreg_nxt  = {bit_in, shreg[UID_WIDTH-1:1]};

    ows_crc8_serial u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (bit_in),
        .crc   (crc)
    );

    // Frame FSM. The result is registered on the edge that takes the last bit so that
    // data_valid, UID_Data and crc_ok are all visible during the CHECK cycle; crc_ok
    // therefore looks one CRC step ahead of the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            shreg      <= '0;
            UID_Data   <= '0;
            crc_ok     <= 1'b0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end else if (frame_start) begin
                state <= ST_SHIFT;
                cnt   <= '0;
                shreg <= '0;
                busy  <= 1'b1;
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (bit_valid) begin
                            shreg <= shreg_nxt;
                            if (cnt == LAST_BIT) begin
                                state      <= ST_CHECK;
                                cnt        <= '0;
                                UID_Data   <= shreg_nxt;
                                crc_ok     <= (crc8_step(crc, bit_in) == '0);
                                data_valid <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    ST_CHECK: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ows_rom_deshifter.sv
// Directed bench for the 1-Wire ROM deshifter: vector table plus corner-case sequences.
module tb_ows_rom_deshifter;

    localparam logic [63:0] GOOD = 64'hA200_0000_01B8_1C02;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic        abort;
    logic        bit_valid;
    logic        bit_in;
    logic [63:0] UID_Data;
    logic        data_valid;
    logic        crc_ok;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int dv_cnt = 0;

    typedef struct {
        logic [63:0] uid;
        logic        ok;
        int          gap;
    } vec_t;

    vec_t vecs[5];

    ows_rom_deshifter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .abort       (abort),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .UID_Data    (UID_Data),
        .data_valid  (data_valid),
        .crc_ok      (crc_ok),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (data_valid) dv_cnt++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Send bits [first .. first+n-1] of uid; maxgap > 0 inserts random idle cycles.
    task automatic send_bits(input logic [63:0] uid, input int first, input int n, input int maxgap);
        for (int i = first; i < first + n; i++) begin
            bit_valid = 1'b1;
            bit_in    = uid[i];
            tick();
            bit_valid = 1'b0;
            if (maxgap > 0 && i < first + n - 1) repeat ($urandom_range(0, maxgap)) tick();
        end
    endtask

    // Full frame from frame_start through the CHECK cycle, with result checks.
    task automatic run_frame(input string name, input logic [63:0] uid, input logic ok, input int maxgap);
        int dv0;
        dv0 = dv_cnt;
        start_pulse();
        chk({name, ".busy_start"}, 64'(busy), 64'd1);
        send_bits(uid, 0, 64, maxgap);
        chk({name, ".dv_latency"}, 64'(data_valid), 64'd1);
        chk({name, ".uid"}, UID_Data, uid);
        chk({name, ".crc_ok"}, 64'(crc_ok), 64'(ok));
        tick();
        chk({name, ".dv_width"}, 64'(data_valid), 64'd0);
        chk({name, ".busy_end"}, 64'(busy), 64'd0);
        chk({name, ".dv_count"}, 64'(dv_cnt - dv0), 64'd1);
    endtask

    initial begin
        logic [63:0] prev;
        int dv0;

        vecs[0] = '{uid: GOOD,                        ok: 1'b1, gap: 0};
        vecs[1] = '{uid: GOOD ^ 64'h0000_0000_0010_0000, ok: 1'b0, gap: 0};
        vecs[2] = '{uid: GOOD ^ 64'h1,                   ok: 1'b0, gap: 0};
        vecs[3] = '{uid: GOOD ^ 64'h8000_0000_0000_0000, ok: 1'b0, gap: 2};
        vecs[4] = '{uid: 64'h0,                          ok: 1'b1, gap: 0};

        rst_n = 1'b0; frame_start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        repeat (3) tick();
        chk("rst.uid", UID_Data, 64'h0);
        chk("rst.dv", 64'(data_valid), 64'd0);
        chk("rst.crc_ok", 64'(crc_ok), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) run_frame($sformatf("vec%0d", v), vecs[v].uid, vecs[v].ok, vecs[v].gap);

        // Abort after 30 bits: nothing delivered, previous frame kept.
        run_frame("pre_abort", GOOD, 1'b1, 0);
        prev = UID_Data;
        dv0  = dv_cnt;
        start_pulse();
        send_bits(GOOD ^ 64'hFF, 0, 30, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort.busy", 64'(busy), 64'd0);
        send_bits(GOOD, 30, 34, 0);
        tick();
        chk("abort.no_dv", 64'(dv_cnt - dv0), 64'd0);
        chk("abort.uid_kept", UID_Data, prev);
        run_frame("post_abort", GOOD, 1'b1, 0);

        // Restart coincident with a strobe at bit 40.
        dv0 = dv_cnt;
        start_pulse();
        send_bits(GOOD, 0, 40, 0);
        frame_start = 1'b1; bit_valid = 1'b1; bit_in = ~GOOD[0];
        tick();
        frame_start = 1'b0; bit_valid = 1'b0;
        send_bits(GOOD, 0, 64, 0);
        chk("restart.uid", UID_Data, GOOD);
        chk("restart.crc_ok", 64'(crc_ok), 64'd1);
        tick();
        chk("restart.dv_count", 64'(dv_cnt - dv0), 64'd1);

        // Stray strobes in IDLE, then a start that coincides with a strobe, then a spaced frame.
        dv0 = dv_cnt;
        send_bits(64'hFFFF_FFFF_FFFF_FFFF, 0, 5, 3);
        chk("idle.busy", 64'(busy), 64'd0);
        frame_start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        frame_start = 1'b0; bit_valid = 1'b0;
        send_bits(GOOD, 0, 64, 15);
        chk("spacing.dv", 64'(data_valid), 64'd1);
        chk("spacing.uid", UID_Data, GOOD);
        chk("spacing.crc_ok", 64'(crc_ok), 64'd1);
        tick();
        // Extra strobes after the frame are ignored.
        send_bits(64'h0, 0, 8, 0);
        tick();
        chk("extra.dv_count", 64'(dv_cnt - dv0), 64'd1);
        chk("extra.busy", 64'(busy), 64'd0);
        chk("extra.uid", UID_Data, GOOD);

        // Asynchronous reset mid-frame, off the clock edges.
        start_pulse();
        send_bits(GOOD, 0, 20, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.uid", UID_Data, 64'h0);
        chk("arst.dv", 64'(data_valid), 64'd0);
        chk("arst.crc_ok", 64'(crc_ok), 64'd0);
        chk("arst.busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_frame("post_arst", GOOD, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule
